// File: rtl/uart_tx_block.sv
// 8N1 UART transmitter with a one-byte holding buffer for gap-free back-to-back frames.
// Bytes arrive on a valid/ready handshake; serial_out idles high between frames.
module uart_tx_block #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] BIT_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state, state_n;
    logic [7:0]         shifter, shifter_n;
    logic [7:0]         hold, hold_n;
    logic               hold_full, hold_full_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [2:0]         bit_idx, bit_idx_n;
    logic               serial_n, busy_n, done_n;
    logic               accept, bit_end;

    assign tx_ready = ~hold_full;
    assign accept   = tx_valid & ~hold_full;
    assign bit_end  = (timer == BIT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    // NOTE: the holding buffer is a single register, so it is cleared on reset
    // together with the rest of the datapath (no RAM here to leave uninitialised).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            shifter    <= 8'h00;
            hold       <= 8'h00;
            hold_full  <= 1'b0;
            timer      <= '0;
            bit_idx    <= 3'd0;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_n;
            shifter    <= shifter_n;
            hold       <= hold_n;
            hold_full  <= hold_full_n;
            timer      <= timer_n;
            bit_idx    <= bit_idx_n;
            serial_out <= serial_n;
            tx_busy    <= busy_n;
            tx_done    <= done_n;
        end
    end

    // NOTE: every variable gets its default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n     = state;
        shifter_n   = shifter;
        hold_n      = hold;
        hold_full_n = hold_full;
        timer_n     = timer;
        bit_idx_n   = bit_idx;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    shifter_n = tx_data;
                    state_n   = START;
                    timer_n   = '0;
                    bit_idx_n = 3'd0;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_n   = '0;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_n   = '0;
                    shifter_n = {1'b0, shifter[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    timer_n = '0;
                    if (hold_full) begin
                        shifter_n   = hold;
                        hold_full_n = 1'b0;
                        state_n     = START;
                    end else if (accept) begin
                        // A byte offered on the last stop clock goes straight to the
                        // shifter; parking it in the buffer would strand it in IDLE.
                        shifter_n = tx_data;
                        state_n   = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (accept && state != IDLE && !(state == STOP && bit_end)) begin
            hold_n      = tx_data;
            hold_full_n = 1'b1;
        end

        // Outputs are registered copies of what the next state will drive.
        busy_n = (state_n != IDLE);
        done_n = (state_n == STOP) && (timer_n == BIT_LAST);
        unique case (state_n)
            START:   serial_n = 1'b0;
            DATA:    serial_n = shifter_n[0];
            default: serial_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_block.sv
// Scoreboard bench for uart_tx_block: three instances (10, 2 and 16 clocks per bit),
// a sampling receiver per instance pops expected bytes and checks every bit clock.
module tb_uart_tx_block;

    localparam int CPB0 = 10;
    localparam int CPB1 = 2;
    localparam int CPB2 = 16;

    logic       clk;
    logic       n_rst;
    logic [7:0] tx_data [3];
    logic [2:0] tx_valid;
    logic [2:0] tx_ready;
    logic [2:0] serial_out;
    logic [2:0] tx_busy;
    logic [2:0] tx_done;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] exp_q [3][$];
    int         done_cnt [3];
    int         busy_cur [3];
    int         last_run [3];

    uart_tx_block #(.CLKS_PER_BIT(CPB0)) dut0 (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .serial_out(serial_out[0]), .tx_busy(tx_busy[0]),
        .tx_done(tx_done[0])
    );
    uart_tx_block #(.CLKS_PER_BIT(CPB1)) dut1 (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .serial_out(serial_out[1]), .tx_busy(tx_busy[1]),
        .tx_done(tx_done[1])
    );
    uart_tx_block #(.CLKS_PER_BIT(CPB2)) dut2 (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .serial_out(serial_out[2]), .tx_busy(tx_busy[2]),
        .tx_done(tx_done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Busy run lengths and done pulses, sampled on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (tx_done[k] === 1'b1) done_cnt[k] = done_cnt[k] + 1;
            if (tx_busy[k] === 1'b1) begin
                busy_cur[k] = busy_cur[k] + 1;
            end else if (busy_cur[k] > 0) begin
                last_run[k] = busy_cur[k];
                busy_cur[k] = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Receiver model: on a low line, checks every clock of the frame against the expected byte.
    task automatic rx_mon(input int k, input int cpb);
        logic [7:0] exp_b;
        logic [7:0] got;
        logic       exp_bit;
        bit         bad;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1 && serial_out[k] === 1'b0) begin
                if (exp_q[k].size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL rx%0d unexpected_frame: got start bit expected idle line", k);
                    repeat (10 * cpb - 1) @(negedge clk);
                end else begin
                    exp_b   = exp_q[k].pop_front();
                    got     = 8'h00;
                    bad     = 1'b0;
                    aborted = 1'b0;
                    for (int b = 0; b < 10 && !aborted; b++) begin
                        for (int j = 0; j < cpb && !aborted; j++) begin
                            if (b != 0 || j != 0) @(negedge clk);
                            if (n_rst !== 1'b1) begin
                                aborted = 1'b1;
                            end else begin
                                exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_b[b-1];
                                if (serial_out[k] !== exp_bit) bad = 1'b1;
                                if (tx_busy[k] !== 1'b1) bad = 1'b1;
                                if (tx_done[k] !== ((b == 9) && (j == cpb - 1))) bad = 1'b1;
                                if (b >= 1 && b <= 8 && j == cpb / 2) got[b-1] = serial_out[k];
                            end
                        end
                    end
                    if (!aborted) begin
                        checks = checks + 1;
                        if (bad || got !== exp_b) begin
                            errors = errors + 1;
                            $display("FAIL rx%0d frame: got byte %h (timing_err=%0d) expected byte %h",
                                     k, got, bad, exp_b);
                        end
                    end
                end
            end
        end
    endtask

    // Offers a byte until accepted; returns the accept cycle. Data is scrambled afterwards.
    task automatic send(input int k, input logic [7:0] d, output int acc);
        int n;
        acc = -1;
        n = 0;
        @(negedge clk);
        tx_valid[k] = 1'b1;
        tx_data[k]  = d;
        while (tx_ready[k] !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (tx_ready[k] !== 1'b1) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL send%0d timeout: got tx_ready=0 expected 1 within 1000 clks", k);
            tx_valid[k] = 1'b0;
        end else begin
            @(posedge clk);
            exp_q[k].push_back(d);
            #1;
            acc = cyc;
            tx_valid[k] = 1'b0;
            tx_data[k]  = ~d;
        end
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (!(tx_busy[k] === 1'b0 && tx_ready[k] === 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL idle%0d timeout: got busy=%b expected 0", k, tx_busy[k]);
        end
        @(negedge clk);
    endtask

    int a1, a2, a3, d0;

    initial begin
        n_rst    = 1'b0;
        tx_valid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            tx_data[k]  = 8'h00;
            done_cnt[k] = 0;
            busy_cur[k] = 0;
            last_run[k] = 0;
        end
        fork
            rx_mon(0, CPB0);
            rx_mon(1, CPB1);
            rx_mon(2, CPB2);
        join_none

        repeat (3) @(negedge clk);
        check("reset_state", {20'h0, serial_out, tx_ready, tx_busy, tx_done},
              {20'h0, 3'b111, 3'b111, 3'b000, 3'b000});
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of the data bits of a frame of zeros.
        d0 = done_cnt[0];
        send(0, 8'h00, a1);
        repeat (35) @(negedge clk);
        check("pre_reset_line_busy", {30'h0, serial_out[0], tx_busy[0]}, 32'h1);
        #2 n_rst = 1'b0;
        #1;
        check("reset_mid_frame", {28'h0, serial_out[0], tx_ready[0], tx_busy[0], tx_done[0]}, 32'hC);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_no_done", done_cnt[0] - d0, 32'h0);

        // Single byte 0xA5.
        d0 = done_cnt[0];
        send(0, 8'hA5, a1);
        wait_idle(0);
        check("a5_busy_len", last_run[0], 32'd100);
        check("a5_done_count", done_cnt[0] - d0, 32'h1);
        check("a5_idle", {30'h0, serial_out[0], tx_ready[0]}, 32'h3);

        // Back-to-back 0x00 then 0xFF.
        d0 = done_cnt[0];
        send(0, 8'h00, a1);
        send(0, 8'hFF, a2);
        check("b2b_ready_low", {31'h0, tx_ready[0]}, 32'h0);
        check("b2b_second_accept", a2 - a1, 32'd1);
        wait_idle(0);
        check("b2b_busy_len", last_run[0], 32'd200);
        check("b2b_done_count", done_cnt[0] - d0, 32'h2);

        // Backpressure: third byte waits for the first frame's stop end plus one clock.
        d0 = done_cnt[0];
        send(0, 8'h11, a1);
        send(0, 8'h22, a2);
        send(0, 8'h33, a3);
        check("bp_third_accept", a3 - a1, 32'd101);
        wait_idle(0);
        check("bp_busy_len", last_run[0], 32'd300);
        check("bp_done_count", done_cnt[0] - d0, 32'h3);

        // Bit-width sweep with 0x3C.
        send(1, 8'h3C, a1);
        wait_idle(1);
        check("cpb2_busy_len", last_run[1], 32'd20);
        send(2, 8'h3C, a1);
        wait_idle(2);
        check("cpb16_busy_len", last_run[2], 32'd160);

        // Data changed right after the accept edge must not reach the line.
        d0 = done_cnt[0];
        send(0, 8'h5A, a1);
        tx_data[0] = 8'hC3;
        wait_idle(0);
        check("datachg_busy_len", last_run[0], 32'd100);
        check("datachg_done_count", done_cnt[0] - d0, 32'h1);

        check("queues_drained", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish within 50000 clks");
        $fatal(1, "watchdog expired");
    end

endmodule
